mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit; consumes the address, store data and memory controls presented by the EX/MEM pipeline register.
- Drives a variable-latency data-memory port using a req/ready handshake.
- Stalls the pipeline while an access is outstanding.
- Returns aligned, extended load data to the MEM/WB path.
- Flags misaligned, illegal and timed-out accesses.

Parameters:
DATA_LENGTH, 32, data and address width in bits.
TIMEOUT_CYCLES, 255, maximum BUSY cycles waiting for mem_ready before abort.
TO_WIDTH, 8, timeout counter width; must satisfy TIMEOUT_CYCLES < 2**TO_WIDTH.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
valid_in  input  1  EX/MEM holds a live instruction
alu_res_in  input  DATA_LENGTH  byte address
w_data_in  input  DATA_LENGTH  store data (rs2)
mem_write_in  input  1  store
mem_read_in  input  1  load
funct3_in  input  3  access size/sign
mem_req  output  1  request to data memory
mem_we  output  1  write request
mem_addr  output  DATA_LENGTH  word-aligned address ({addr[31:2],2'b00})
mem_be  output  4  byte enables
mem_wdata  output  DATA_LENGTH  lane-replicated store data
mem_ready  input  1  memory completes current request
mem_rdata  input  DATA_LENGTH  read word, valid when mem_ready=1
stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM
load_data_out  output  DATA_LENGTH  extended load result
load_valid  output  1  load_data_out valid this cycle
access_fault  output  1  one-cycle fault pulse

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data_out, load_valid, access_fault all 0; timeout counter 0.
  - Reset mid-BUSY abandons the transaction; no fault is raised.
- Access condition: access = valid_in & (mem_read_in | mem_write_in).
- Sizes by funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3, or read & write both set, is illegal.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Access, legal and aligned:
    - Register mem_addr, mem_be, mem_wdata, mem_we, funct3 and addr[1:0].
    - Next state BUSY.
    - stall=1 combinationally this cycle.
  - Access, illegal or misaligned:
    - access_fault=1 the next cycle for one cycle; stay IDLE.
    - stall=0; no request issued.
  - No access: stall=0.
- BUSY:
  - mem_req=1, stall=1; counter increments each cycle.
  - mem_ready=1:
    - For loads, capture the extended load data into load_data_out.
    - Drop mem_req next cycle; next state DONE.
  - Counter reaches TIMEOUT_CYCLES with no ready:
    - Drop mem_req; access_fault pulse.
    - Next state DONE with load_valid=0.
- DONE:
  - stall=0; load_valid=1 if the access was a load that completed.
  - Next state IDLE unconditionally, so the same EX/MEM entry is never reissued.
  - Counter cleared.
- Latency: minimum 3 cycles per access (IDLE detect, BUSY with immediate ready, DONE). Each extra wait cycle adds one.
- Byte enables:
  - SB/LB/LBU: 4'b0001 << addr[1:0].
  - SH/LH/LHU: 4'b0011 << addr[1:0].
  - Word: 4'b1111.
- Store data: SB → {4{w_data[7:0]}}; SH → {2{w_data[15:0]}}; SW as-is.
- Load extraction:
  - Select the byte/half lane by the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- load_data_out holds its value until the next completed load.
- mem_ready outside BUSY is ignored.
- mem_req, mem_addr, mem_be, mem_wdata and mem_we are stable for the whole of BUSY.

Decomposition:
- Shared package lsu_pkg:
  - funct3 load/store localparams.
  - lsu_state_t enum {IDLE, BUSY, DONE}.
  - Function be_gen(size, addr_lo).
- Sub-module load_align:
  - Combinational.
  - Inputs: rdata, addr_lo, funct3.
  - Output: extended DATA_LENGTH result.

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, memory ready in the first BUSY cycle → mem_addr=0x104, mem_be=1111, mem_we=1; stall high 2 cycles; no load_valid.
- LB addr 0x203, rdata 0x80FF_0000, ready after 3 waits → load_data_out=0xFFFFFF80; load_valid pulses in DONE; stall high 5 cycles.
- LHU addr 0x202, rdata 0x8001_1234 → be=1100, load_data_out=0x00008001. Same access as LH → 0xFFFF8001.
- SB addr 0x101, data 0x000000AB → be=0010, mem_wdata=0xABABABAB.
- LW addr 0x102 → access_fault one cycle; no mem_req; stall=0. funct3=011 load → same fault response.
- LW with mem_ready never asserted → access_fault after 255 BUSY cycles, then DONE→IDLE. Repeat with rst=0 in BUSY cycle 4 → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
package lsu_pkg;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Access size, taken from funct3[1:0]
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   // Byte enables for an access of the given size at the given byte offset
   function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << addr_lo;
         SZ_HALF: be = 4'b0011 << addr_lo;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/load_align.sv
// Selects the byte/halfword lane of a read word and sign/zero-extends it.
module load_align
   import lsu_pkg::*;
#(
   parameter int DATA_LENGTH = 32
) (
   input  logic [DATA_LENGTH-1:0] i_rdata,
   input  logic [1:0]             i_addr_lo,
   input  logic [2:0]             i_funct3,
   output logic [DATA_LENGTH-1:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane select by byte offset, then extend according to the load kind
   always_comb begin
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

      case (i_funct3)
         F3_LB:   o_result = {{(DATA_LENGTH-8){w_byte[7]}}, w_byte};
         F3_LH:   o_result = {{(DATA_LENGTH-16){w_half[15]}}, w_half};
         F3_LBU:  o_result = {{(DATA_LENGTH-8){1'b0}}, w_byte};
         F3_LHU:  o_result = {{(DATA_LENGTH-16){1'b0}}, w_half};
         default: o_result = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues one data-memory request per EX/MEM
// entry over a req/ready handshake, stalls the pipeline while it is
// outstanding, and returns aligned load data or a one-cycle fault pulse.
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int DATA_LENGTH    = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_WIDTH       = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   valid_in,
   input  logic [DATA_LENGTH-1:0] alu_res_in,
   input  logic [DATA_LENGTH-1:0] w_data_in,
   input  logic                   mem_write_in,
   input  logic                   mem_read_in,
   input  logic [2:0]             funct3_in,
   output logic                   mem_req,
   output logic                   mem_we,
   output logic [DATA_LENGTH-1:0] mem_addr,
   output logic [3:0]             mem_be,
   output logic [DATA_LENGTH-1:0] mem_wdata,
   input  logic                   mem_ready,
   input  logic [DATA_LENGTH-1:0] mem_rdata,
   output logic                   stall,
   output logic [DATA_LENGTH-1:0] load_data_out,
   output logic                   load_valid,
   output logic                   access_fault
);

   lsu_state_t r_state;
   lsu_state_t w_state_nxt;

   logic [TO_WIDTH-1:0]    r_cnt;
   logic [DATA_LENGTH-1:0] r_mem_addr;
   logic [3:0]             r_mem_be;
   logic [DATA_LENGTH-1:0] r_mem_wdata;
   logic                   r_mem_we;
   logic [2:0]             r_funct3;
   logic [1:0]             r_addr_lo;
   logic                   r_is_load;
   logic                   r_load_ok;
   logic [DATA_LENGTH-1:0] r_load_data;
   logic                   r_fault;

   logic                   w_access;
   logic                   w_illegal;
   logic                   w_misaligned;
   logic                   w_start;
   logic                   w_fault_req;
   logic                   w_timeout;
   logic [1:0]             w_size;
   logic [1:0]             w_addr_lo;
   logic [DATA_LENGTH-1:0] w_store_data;
   logic [DATA_LENGTH-1:0] w_aligned;

   assign w_size    = funct3_in[1:0];
   assign w_addr_lo = alu_res_in[1:0];

   // Decode the EX/MEM entry: legality, alignment and whether to start
   always_comb begin
      w_access  = valid_in & (mem_read_in | mem_write_in);
      w_illegal = 1'b0;
      if (mem_read_in && mem_write_in) begin
         w_illegal = 1'b1;
      end else if (mem_read_in) begin
         case (funct3_in)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: w_illegal = 1'b0;
            default:                             w_illegal = 1'b1;
         endcase
      end else begin
         case (funct3_in)
            F3_SB, F3_SH, F3_SW: w_illegal = 1'b0;
            default:             w_illegal = 1'b1;
         endcase
      end
      w_misaligned = ((w_size == SZ_HALF) && w_addr_lo[0]) ||
                     ((w_size == SZ_WORD) && (w_addr_lo != 2'b00));
      w_start      = w_access & ~w_illegal & ~w_misaligned;
      w_fault_req  = w_access & (w_illegal | w_misaligned);
   end

   // Replicate narrow store data across all lanes so the byte enables pick it
   always_comb begin
      case (w_size)
         SZ_BYTE: w_store_data = {4{w_data_in[7:0]}};
         SZ_HALF: w_store_data = {2{w_data_in[15:0]}};
         default: w_store_data = w_data_in;
      endcase
   end

   // Last permitted BUSY cycle passed without a ready
   assign w_timeout = (r_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1)) & ~mem_ready;

   load_align #(
      .DATA_LENGTH (DATA_LENGTH)
   ) u_load_align (
      .i_rdata   (mem_rdata),
      .i_addr_lo (r_addr_lo),
      .i_funct3  (r_funct3),
      .o_result  (w_aligned)
   );

   // FSM next state plus the combinational request and stall outputs
   always_comb begin
      w_state_nxt = r_state;
      stall       = 1'b0;
      mem_req     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               stall       = 1'b1;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            mem_req = 1'b1;
            stall   = 1'b1;
            if (mem_ready || w_timeout) begin
               w_state_nxt = DONE;
            end
         end
         // DONE always retires the entry so it is never reissued
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Timeout counter: counts BUSY cycles, cleared everywhere else
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (r_state == BUSY) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end

   // Latch the request at issue so it stays stable throughout BUSY
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_mem_we    <= 1'b0;
         r_funct3    <= '0;
         r_addr_lo   <= '0;
         r_is_load   <= 1'b0;
      end else if ((r_state == IDLE) && w_start) begin
         r_mem_addr  <= {alu_res_in[DATA_LENGTH-1:2], 2'b00};
         r_mem_be    <= be_gen(w_size, w_addr_lo);
         r_mem_wdata <= w_store_data;
         r_mem_we    <= mem_write_in;
         r_funct3    <= funct3_in;
         r_addr_lo   <= w_addr_lo;
         r_is_load   <= mem_read_in;
      end
   end

   // Capture completed loads; load data holds until the next completed load
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_load_data <= '0;
         r_load_ok   <= 1'b0;
      end else if (r_state == BUSY) begin
         r_load_ok <= mem_ready & r_is_load;
         if (mem_ready && r_is_load) begin
            r_load_data <= w_aligned;
         end
      end
   end

   // One-cycle fault pulse for rejected accesses and timeouts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fault <= 1'b0;
      end else begin
         r_fault <= ((r_state == IDLE) && w_fault_req) ||
                    ((r_state == BUSY) && w_timeout);
      end
   end

   assign mem_we        = r_mem_we;
   assign mem_addr      = r_mem_addr;
   assign mem_be        = r_mem_be;
   assign mem_wdata     = r_mem_wdata;
   assign load_data_out = r_load_data;
   assign load_valid    = (r_state == DONE) & r_load_ok;
   assign access_fault  = r_fault;

endmodule
